seq_mag_cmp_ctrl: RTL and testbench

- Sequencer that compares two WIDTH-bit operands by scheduling a single 4-bit magnitude-compare slice over successive nibbles, MSB nibble first.
- Stops at the first unequal nibble (early exit).
- Used where wide compares are rare and area matters more than latency, e.g. threshold checks next to small datapaths.
- Start/busy/done handshake; results are registered and held until the next start.

---
 rtl/seq_mag_cmp_ctrl.sv | 138 +++++++++++++
 tb/tb_seq_mag_cmp_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_cmp_ctrl.sv
// seq_mag_cmp_ctrl
// Compares two WIDTH-bit operands one nibble per cycle, MSB nibble first,
// using a single 4-bit magnitude-compare slice. The compare stops at the
// first unequal nibble. A start/busy/done handshake is used, and the results
// are held until the next accepted start.
//
// Optional feature macro: SEQ_MAG_CMP_SIGNED_EN
//   When it is defined, the operands are compared as two's complement. Bit 3
//   of both MSB nibbles is inverted before the slice sees them.
//   When it is undefined, the compare is purely unsigned.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start    compare request; sampled only when not busy (IDLE or DONE)
//   a, b     operands; captured on an accepted start
//   busy     compare in progress
//   done     single-cycle pulse; results valid
//   equal    A == B
//   gt       A > B
//   lt       A < B
//   nib_cnt  nibbles examined for the last result (1..NIB)

module seq_mag_cmp_ctrl #(
   parameter int WIDTH = 16,
   parameter int NIB   = WIDTH / 4,
   parameter int CW    = $clog2(NIB + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             equal,
   output logic             gt,
   output logic             lt,
   output logic [CW-1:0]    nib_cnt
);

   localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]    idx;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic             nib_gt;
   logic             nib_lt;

   // Nibble select feeding the single shared compare slice
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int unsigned i = 0; i < NIB; i++) begin
         if (idx == IW'(i)) begin
            a_nib = a_q[4*i +: 4];
            b_nib = b_q[4*i +: 4];
         end
      end
`ifdef SEQ_MAG_CMP_SIGNED_EN
      // Flipping the sign bit of the MSB nibble maps two's complement order
      // onto unsigned order; the lower nibbles are already unsigned.
      if (idx == IW'(NIB - 1)) begin
         a_nib[3] = ~a_nib[3];
         b_nib[3] = ~b_nib[3];
      end
`endif
      nib_gt = (a_nib > b_nib);
      nib_lt = (a_nib < b_nib);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         equal   <= 1'b0;
         gt      <= 1'b0;
         lt      <= 1'b0;
         nib_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            // DONE accepts start exactly like IDLE, so back-to-back compares
            // need no idle gap.
            IDLE, DONE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  idx     <= IW'(NIB - 1);
                  equal   <= 1'b0;
                  gt      <= 1'b0;
                  lt      <= 1'b0;
                  nib_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= CMP;
               end else begin
                  state <= IDLE;
               end
            end
            CMP: begin
               nib_cnt <= nib_cnt + CW'(1);
               if (nib_gt || nib_lt) begin
                  gt    <= nib_gt;
                  lt    <= nib_lt;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (idx == '0) begin
                  equal <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mag_cmp_ctrl.sv
// tb_seq_mag_cmp_ctrl
// Scoreboard bench for seq_mag_cmp_ctrl (WIDTH=16).
// The driver pushes one expected transaction per accepted start. A
// negedge monitor then checks the DUT outputs in every cycle against that
// queue: busy cycles, the done cycle, and the held results afterwards.

module tb_seq_mag_cmp_ctrl;

   localparam int W   = 16;
   localparam int NIB = W / 4;
   localparam int CW  = $clog2(NIB + 1);

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  a     = '0;
   logic [W-1:0]  b     = '0;
   logic          busy;
   logic          done;
   logic          equal;
   logic          gt;
   logic          lt;
   logic [CW-1:0] nib_cnt;
   logic [7:0]    outv;

   seq_mag_cmp_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .equal   (equal),
      .gt      (gt),
      .lt      (lt),
      .nib_cnt (nib_cnt)
   );

   assign outv = {busy, done, equal, gt, lt, nib_cnt};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int   st;
      int   dn;
      logic eq;
      logic g;
      logic l;
      int   k;
   } txn_t;

   txn_t       q[$];
   logic [7:0] held  = '0;
   bit         armed = 1'b0;
   int         n_checks = 0;
   int         n_pass   = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got {busy,done,eq,gt,lt,nib}=%b expected %b",
                    name, cyc, act, exp);
   endtask

   // Reference model. The result comes from native integer compares. k is the
   // position of the first differing nibble, counted from the MSB.
   function automatic txn_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int c);
      txn_t t;
      bit   found;
      t.st = c;
`ifdef SEQ_MAG_CMP_SIGNED_EN
      t.g  = ($signed(x) > $signed(y));
      t.l  = ($signed(x) < $signed(y));
`else
      t.g  = (x > y);
      t.l  = (x < y);
`endif
      t.eq  = (x == y);
      t.k   = NIB;
      found = 1'b0;
      for (int i = NIB - 1; i >= 0; i--) begin
         if (!found && (x[4*i +: 4] != y[4*i +: 4])) begin
            found = 1'b1;
            t.k   = NIB - i;
         end
      end
      t.dn = c + t.k + 1;
      return t;
   endfunction

   // Monitor: checks the outputs in every cycle against the scoreboard
   always @(negedge clk) begin
      if (armed) begin
         if (q.size() > 0 && cyc == q[0].dn) begin
            chk("done_result", outv, {1'b0, 1'b1, q[0].eq, q[0].g, q[0].l, 3'(q[0].k)});
            held = {2'b00, q[0].eq, q[0].g, q[0].l, 3'(q[0].k)};
            void'(q.pop_front());
         end else if (q.size() > 0 && cyc > q[0].st) begin
            chk("busy_phase", outv, {1'b1, 1'b0, 3'b000, 3'(cyc - q[0].st - 1)});
         end else begin
            chk("idle_hold", outv, held);
         end
      end
   end

   // One driven cycle. A start counts as accepted only if the model says the
   // DUT is idle or in its done cycle.
   task automatic drive(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
      @(posedge clk);
      #1;
      start = s;
      a     = x;
      b     = y;
      if (s && (q.size() == 0 || cyc >= q[$].dn)) q.push_back(model(x, y, cyc));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), W'($urandom));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      start = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.delete();
      held = '0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (q.size() > 0 && guard < 100) begin
         drive(1'b0, W'($urandom), W'($urandom));
         guard++;
      end
      n_checks++;
      if (q.size() == 0) n_pass++;
      else begin
         $display("FAIL drain_timeout: %0d transactions still pending, required 0", q.size());
         q.delete();
      end
   endtask

   logic [W-1:0] rx;
   logic [W-1:0] ry;
   logic [3:0]   flip;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset_state", outv, 8'h00);
      armed = 1'b1;
      idle(2);

      // Equal operands: all four nibbles examined
      drive(1'b1, 16'h1234, 16'h1234);
      wait_idle();
      idle(2);

      // MSB nibble decides the result
      drive(1'b1, 16'h8000, 16'h7FFF);
      wait_idle();
      idle(2);

      // Third nibble decides; results must hold through the idle cycles
      drive(1'b1, 16'h12A4, 16'h12B4);
      wait_idle();
      idle(10);

      // A start while busy is ignored
      drive(1'b1, 16'h0001, 16'h0000);
      drive(1'b1, 16'hFFFF, 16'h0000);
      drive(1'b0, 16'hFFFF, 16'h0000);
      wait_idle();
      idle(3);

      // Back-to-back: start is asserted in the done cycle
      drive(1'b1, 16'h1234, 16'h1200);
      for (int g = 0; g < 20 && q.size() > 0 && (cyc + 1) < q[0].dn; g++)
         drive(1'b0, 16'h0, 16'h0);
      drive(1'b1, 16'h0000, 16'h0001);
      drive(1'b0, 16'h0, 16'h0);
      wait_idle();
      idle(2);

      // Reset in the middle of a compare abandons it
      drive(1'b1, 16'hAAAA, 16'hAAAA);
      drive(1'b0, 16'h0, 16'h0);
      do_reset();
      idle(3);
      drive(1'b1, 16'h5555, 16'h5554);
      wait_idle();
      idle(2);

      // Randomized traffic, biased toward long equal prefixes
      for (int it = 0; it < 500; it++) begin
         int r;
         r = $urandom_range(0, 99);
         rx = W'($urandom);
         case ($urandom_range(0, 3))
            0: ry = rx;
            1, 2: begin
               int p;
               p    = $urandom_range(0, NIB - 1);
               flip = 4'($urandom_range(1, 15));
               ry   = rx;
               ry[4*p +: 4] = ry[4*p +: 4] ^ flip;
            end
            default: ry = W'($urandom);
         endcase
         if (r < 2) do_reset();
         else if (r < 55) drive(1'b1, rx, ry);
         else drive(1'b0, rx, ry);
      end
      drive(1'b0, 16'h0, 16'h0);
      wait_idle();
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
